// File: rtl/npu_result_drain.sv
// Result drain / requantizer for the 8x8 MAC array: snapshot, round-shift-saturate, stream, clear.
// Optional build macro NPU_DRAIN_RELU_EN clamps negative rounded values to zero before saturation.
//
// state | meaning
// IDLE  | waiting for start, bank holds last tile
// DRAIN | presenting bank[idx] on the output stream
// CLEAR | one-cycle mac_clear/done pulse
module npu_result_drain #(
  parameter int ROWS  = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  localparam int IDX_W = $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0]              shift,
  input  logic signed [ACC_W-1:0] results [ROWS],
  output logic                    mac_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_row,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam int Q_MAX_I = 2 ** (OUT_W - 1) - 1;
  localparam int Q_MIN_I = -(2 ** (OUT_W - 1));
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W + 1)'(Q_MAX_I);
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W + 1)'(Q_MIN_I);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [4:0]              shift_q;
  logic signed [ACC_W-1:0] bank [ROWS];
  logic                    drain;
  logic                    last_row;

  // One extra bit keeps max-positive plus the rounding term from wrapping.
  function automatic logic signed [OUT_W-1:0] quant(input logic signed [ACC_W-1:0] x,
                                                    input logic [4:0] sh);
    logic signed [ACC_W:0] xw;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    xw  = {x[ACC_W-1], x};
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    r = (xw + rnd) >>> sh;
`ifdef NPU_DRAIN_RELU_EN
    if (r < 0) r = '0;
`endif
    if (r > Q_MAX) r = Q_MAX;
    else if (r < Q_MIN) r = Q_MIN;
    return r[OUT_W-1:0];
  endfunction

  assign drain    = (state == S_DRAIN);
  assign last_row = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      shift_q <= '0;
      for (int i = 0; i < ROWS; i++) bank[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < ROWS; i++) bank[i] <= results[i];
            shift_q <= shift;
            idx     <= '0;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (last_row) state <= S_CLEAR;
            else          idx   <= idx + 1'b1;
          end
        end
        S_CLEAR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    out_valid = drain;
    out_row   = drain ? idx : '0;
    out_last  = drain && last_row;
    out_data  = drain ? quant(bank[idx], shift_q) : '0;
    mac_clear = (state == S_CLEAR);
    done      = (state == S_CLEAR);
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_npu_result_drain.sv
// Directed bench for npu_result_drain: hand-computed requantized values, stalls, reset and start-ignore cases.
module tb_npu_result_drain;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [4:0]         shift;
  logic signed [31:0] results [8];
  logic               mac_clear;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic [2:0]         out_row;
  logic               out_last;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int c0       = 0;
  int exp_q [8];

  npu_result_drain dut (
    .clk(clk), .rst(rst), .start(start), .shift(shift), .results(results),
    .mac_clear(mac_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 8; i++) results[i] = v;
  endtask

  // Runs one unstalled tile with the current results/shift, expecting exp_q per row.
  task automatic run_tile();
    start = 1'b1;
    step();
    start = 1'b0;
    c0 = cyc;
    for (int r = 0; r < 8; r++) begin
      check("valid", 32'(out_valid), 1);
      check("row", 32'(out_row), r);
      check("data", out_data, exp_q[r]);
      check("last", 32'(out_last), (r == 7) ? 1 : 0);
      check("clear_in_drain", 32'(mac_clear), 0);
      step();
    end
    check("clear_pulse", 32'(mac_clear), 1);
    check("done_pulse", 32'(done), 1);
    check("done_latency", cyc - c0, 8);
    check("valid_in_clear", 32'(out_valid), 0);
    step();
    check("done_low", 32'(done), 0);
    check("clear_low", 32'(mac_clear), 0);
    check("busy_low", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; shift = 5'd0; out_ready = 1'b1;
    set_all(0);
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_row", 32'(out_row), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_clear", 32'(mac_clear), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();

    // 1000 >> 3 with rounding -> 125 on every row
    set_all(1000); shift = 5'd3;
    for (int i = 0; i < 8; i++) exp_q[i] = 125;
    run_tile();

    // saturation both ways
    set_all(0); results[0] = 5000; results[1] = -5000; results[2] = 7; shift = 5'd2;
    for (int i = 0; i < 8; i++) exp_q[i] = 0;
    exp_q[0] = 127; exp_q[1] = -128; exp_q[2] = 2;
    run_tile();

    // widest positive with max shift, no wrap
    set_all(0); results[0] = 32'sh7FFF_FFFF; results[1] = 32'sh8000_0000; shift = 5'd31;
    for (int i = 0; i < 8; i++) exp_q[i] = 0;
    exp_q[0] = 1; exp_q[1] = -1;
    run_tile();

    // round-half-up on both signs, shift 0 passthrough
    set_all(0); results[0] = 12; results[1] = -12; results[2] = 11; shift = 5'd3;
    for (int i = 0; i < 8; i++) exp_q[i] = 0;
    exp_q[0] = 2; exp_q[1] = -1; exp_q[2] = 1;
    run_tile();

    set_all(0); results[0] = 3; results[1] = -50; results[2] = 200; shift = 5'd0;
    for (int i = 0; i < 8; i++) exp_q[i] = 0;
    exp_q[0] = 3; exp_q[2] = 127;
`ifdef NPU_DRAIN_RELU_EN
    exp_q[1] = 0;
`else
    exp_q[1] = -50;
`endif
    run_tile();

    // backpressure at row 2 for 3 cycles, plus start/results changes mid-drain
    set_all(1000); shift = 5'd3;
    start = 1'b1; step(); start = 1'b0; c0 = cyc;
    step(); step();
    out_ready = 1'b0;
    set_all(-7); shift = 5'd0;
    for (int k = 0; k < 4; k++) begin
      check("stall_row", 32'(out_row), 2);
      check("stall_data", out_data, 125);
      check("stall_valid", 32'(out_valid), 1);
      if (k == 1) start = 1'b1;
      if (k < 3) step();
      start = 1'b0;
    end
    out_ready = 1'b1;
    step();
    for (int r = 3; r < 8; r++) begin
      check("post_stall_row", 32'(out_row), r);
      check("post_stall_data", out_data, 125);
      step();
    end
    check("stall_done", 32'(done), 1);
    check("stall_done_latency", cyc - c0, 11);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_clear_dropped", 32'(busy), 0);
    check("start_in_clear_valid", 32'(out_valid), 0);
    step();
    check("still_idle", 32'(busy), 0);

    // async reset at row 4 abandons the tile
    set_all(1000); shift = 5'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int r = 0; r < 4; r++) step();
    check("pre_rst_row", 32'(out_row), 4);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_clear", 32'(mac_clear), 0);
    rst = 1'b0;
    step();
    check("no_clear_after_rst", 32'(mac_clear), 0);
    check("idle_after_rst", 32'(out_valid), 0);

    set_all(16); shift = 5'd2;
    for (int i = 0; i < 8; i++) exp_q[i] = 4;
    run_tile();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
